mem_responder: RTL
==================

Name: mem_responder

Overview:
- Configurable memory-side responder for the core's instruction/data request interface (req/gnt/rvalid/err, 32-bit address, byte enables).
- Drop-in replacement for the plain single-port RAM on either memory port of the single-core SoC.
- Adds programmable grant wait states, programmable response latency and an address-range error response.
- Used to stress the core's fetch and load/store units under non-ideal memory timing.

Parameters:
ADDR_WIDTH, 32, byte address width of addr_i
DATA_WIDTH, 32, data width; fixed at 32 (be_i is 4 bits)
NUM_WORDS, 256, memory depth in 32-bit words; power of two
BASE_ADDR, 32'h0, byte address of word 0; must be NUM_WORDS*4 aligned
GNT_WAIT, 0, wait-state cycles before gnt_o (0..15)
RESP_LAT, 1, cycles from grant cycle to rvalid_o (1..4)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_ni  in  1  reset, synchronous, active-low
req_i  in  1  request valid; held until gnt_o by initiator
gnt_o  out  1  request accepted this cycle
addr_i  in  ADDR_WIDTH  byte address; bits [1:0] ignored
we_i  in  1  1 = write, 0 = read
be_i  in  4  byte enables for writes
wdata_i  in  32  write data
rvalid_o  out  1  response valid (exactly one per grant, reads and writes)
rdata_o  out  32  read data, valid with rvalid_o
err_o  out  1  error response, valid with rvalid_o

Behaviour:
- Reset (rst_ni low at clk edge):
  - rvalid_o=0, err_o=0, rdata_o=0; response pipeline flushed; wait counter=0; FSM->IDLE.
  - gnt_o forced 0 while rst_ni low.
  - Memory array is NOT reset; contents survive reset.
  - Reset mid-transaction drops all in-flight responses; no rvalid_o for them after reset release.
- Grant FSM, states IDLE and WAIT:
  - IDLE, req_i=1, GNT_WAIT=0: gnt_o=1 combinationally the same cycle; stay IDLE.
  - IDLE, req_i=1, GNT_WAIT>0: gnt_o=0; cnt<=1; ->WAIT.
  - WAIT, req_i=1, cnt<GNT_WAIT: gnt_o=0; cnt++.
  - WAIT, req_i=1, cnt==GNT_WAIT: gnt_o=1; cnt<=0; ->IDLE.
  - WAIT, req_i=0 (protocol violation): cnt<=0; ->IDLE; no grant.
  - Back-to-back: req_i high the cycle after a grant restarts the wait sequence, so every grant costs exactly GNT_WAIT stall cycles.
- Access at grant (req_i & gnt_o):
  - Word index = (addr_i - BASE_ADDR) >> 2.
  - In range iff BASE_ADDR <= addr_i < BASE_ADDR + 4*NUM_WORDS.
  - In-range write: update bytes where be_i[k]=1 with wdata_i[8k+7:8k] at that clock edge; response rdata=0, err=0.
  - In-range read: sample the word at grant; response rdata=word, err=0.
  - Out-of-range access (read or write): memory untouched; response rdata=0, err=1.
- Response pipeline:
  - Shift register of depth RESP_LAT carrying {valid, rdata, err}.
  - A grant at cycle N gives rvalid_o=1 at cycle N+RESP_LAT for exactly one cycle.
  - No backpressure: responses are never stalled or reordered.
  - Up to RESP_LAT responses may be outstanding.
  - rdata_o=0 and err_o=0 whenever rvalid_o=0.
- Read-after-write: write granted at N, read of the same word granted at N+1 returns the new data.
- Address wrap: none; addresses past the top of the range error rather than alias.
- be_i=4'b0000 write: no bytes change; a normal response is still returned.

Test Plan:
- GNT_WAIT=0, RESP_LAT=1: write 0xDEADBEEF to 0x10, be=4'hF, then read 0x10 -> gnt same cycle as req each time; write rvalid with rdata=0 at N+1; read rvalid with rdata=0xDEADBEEF at N+1.
- GNT_WAIT=3: req held from cycle 0 -> gnt_o=1 only at cycle 3; a back-to-back second req is granted at cycle 7.
- RESP_LAT=3, reads granted at cycles 0,1,2 (words preloaded 0x1, 0x2, 0x3) -> rvalid at 3,4,5 with rdata 0x1, 0x2, 0x3 in order.
- Byte enables: word 0x11223344, write 0xAABBCCDD with be=4'b0101 -> read returns 0x11BB33DD.
- BASE_ADDR=0x1000, NUM_WORDS=256: read 0x1400 and write 0x0FFC -> both return err_o=1, rdata=0; read 0x13FC -> err_o=0.
- RESP_LAT=2: grant a read, assert rst_ni=0 the next cycle for 1 cycle -> no rvalid_o ever; memory contents unchanged after reset.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: word memory on the req/gnt/rvalid/err port with programmable grant wait (GNT_WAIT), response latency (RESP_LAT) and range errors; ports clk_i, rst_ni, req_i/gnt_o, addr_i, we_i, be_i, wdata_i in; rvalid_o, rdata_o, err_o out
module mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int GNT_WAIT = 0,
  parameter int RESP_LAT = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o
);
  localparam int IW = $clog2(NUM_WORDS);
  localparam int AW = IW + 2;
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [ADDR_WIDTH-1:0] off;
  logic borrow;
  logic in_range;
  logic acc;
  logic [IW-1:0] widx;
  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
  logic pv [RESP_LAT];
  logic [DATA_WIDTH-1:0] pd [RESP_LAT];
  logic pe [RESP_LAT];
  always_comb begin
    {borrow, off} = {1'b0, addr_i} - {1'b0, BASE_ADDR};
    in_range = !borrow && ((off >> AW) == '0);
    widx = off[AW-1:2];
    gnt_o = rst_ni && req_i && (GNT_WAIT == 0 ? state == IDLE : (state == WAIT && cnt == 4'(GNT_WAIT)));
    acc = req_i && gnt_o;
    rvalid_o = pv[RESP_LAT-1];
    rdata_o = pd[RESP_LAT-1];
    err_o = pe[RESP_LAT-1];
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni || !req_i || gnt_o) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= WAIT;
      cnt <= cnt + 4'd1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (acc && we_i && in_range)
      for (int k = 0; k < 4; k++)
        if (be_i[k]) mem[widx][8*k +: 8] <= wdata_i[8*k +: 8];
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < RESP_LAT; i++) begin
        pv[i] <= 1'b0;
        pd[i] <= '0;
        pe[i] <= 1'b0;
      end
    end else begin
      pv[0] <= acc;
      pe[0] <= acc && !in_range;
      pd[0] <= (acc && !we_i && in_range) ? mem[widx] : '0;
      for (int i = 1; i < RESP_LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
        pe[i] <= pe[i-1];
      end
    end
  end
endmodule
